// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: writes a pattern to a block of SDRAM words, reads it back and counts mismatches; define SDRAM_TESTER_LOOP_EN to rerun passing tests automatically
module sdram_pattern_tester #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = ADDR_WIDTH'(22'h0CAFEE),
  parameter int WORD_COUNT = 4,
  parameter int PATTERN_MODE = 0,
  parameter logic [15:0] PATTERN_SEED = 16'hFACE,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [1:0]            command,
  output logic [ADDR_WIDTH-1:0] data_address,
  output logic [DATA_WIDTH-1:0] data_write,
  input  logic [DATA_WIDTH-1:0] data_read,
  input  logic                  data_next,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] fail_address,
  output logic [DATA_WIDTH-1:0] fail_data
`ifdef SDRAM_TESTER_LOOP_EN
  ,
  output logic [15:0]           loop_count
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WORD_COUNT - 1);
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] idx, idx_nx;
  logic [15:0] lfsr, lfsr_nx;
  logic [31:0] wd;
  logic busy_s, wr_hs, rd_hs, hs, last, wd_exp, mismatch, restart, loop_go;
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] i, input logic [15:0] l);
    logic [15:0] v;
    v = PATTERN_MODE == 2 ? l : PATTERN_MODE == 1 ? 16'(i) ^ PATTERN_SEED : PATTERN_SEED;
    return v[DATA_WIDTH-1:0];
  endfunction
  assign busy_s = state == S_WRITE || state == S_READ;
  assign wr_hs = state == S_WRITE && data_next;
  assign rd_hs = state == S_READ && data_ready;
  assign hs = wr_hs || rd_hs;
  assign last = idx == LAST;
  assign idx_nx = idx + 1'b1;
  assign wd_exp = busy_s && !hs && wd >= WD_LIMIT;
  assign mismatch = rd_hs && data_read != pattern(idx, lfsr);
  assign lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign restart = (state == S_IDLE || state == S_DONE) && state_n == S_WRITE;
`ifdef SDRAM_TESTER_LOOP_EN
  assign loop_go = state == S_DONE && pass;
`else
  assign loop_go = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  // next state: handshakes advance, the watchdog aborts, start (or a passing loop) restarts
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_WRITE : S_IDLE;
      S_WRITE: state_n = wr_hs && last ? S_READ : wd_exp ? S_DONE : S_WRITE;
      S_READ:  state_n = (rd_hs && last) || wd_exp ? S_DONE : S_READ;
      default: state_n = start || loop_go ? S_WRITE : S_DONE;
    endcase
  end
  // registered outputs, word index, pattern generator, watchdog and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      command <= 2'd0;
      data_address <= '0;
      data_write <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      timeout <= 1'b0;
      error_count <= '0;
      fail_address <= '0;
      fail_data <= '0;
      idx <= '0;
      lfsr <= PATTERN_SEED;
      wd <= '0;
`ifdef SDRAM_TESTER_LOOP_EN
      loop_count <= '0;
`endif
    end else begin
      command <= state_n == S_WRITE ? 2'd1 : state_n == S_READ ? 2'd2 : 2'd0;
      busy <= state_n == S_WRITE || state_n == S_READ;
      wd <= busy_s && state_n == state && !hs ? wd + 32'd1 : 32'd0;
      if (restart) begin
        idx <= '0;
        lfsr <= PATTERN_SEED;
        data_address <= BASE_ADDRESS;
        data_write <= pattern('0, PATTERN_SEED);
        done <= 1'b0;
        pass <= 1'b0;
        timeout <= 1'b0;
        error_count <= '0;
        fail_address <= '0;
        fail_data <= '0;
`ifdef SDRAM_TESTER_LOOP_EN
        loop_count <= loop_count + 16'(loop_go);
`endif
      end else if (hs && !last) begin
        idx <= idx_nx;
        lfsr <= lfsr_nx;
        data_address <= data_address + 1'b1;
        data_write <= pattern(idx_nx, lfsr_nx);
      end else if (wr_hs) begin
        idx <= '0;
        lfsr <= PATTERN_SEED;
        data_address <= BASE_ADDRESS;
      end
      if (mismatch) begin
        error_count <= error_count == 16'hFFFF ? error_count : error_count + 16'd1;
        if (error_count == 16'd0) begin
          fail_address <= data_address;
          fail_data <= data_read;
        end
      end
      if (rd_hs && last) begin
        done <= 1'b1;
        pass <= error_count == 16'd0 && !mismatch;
      end
      if (wd_exp) begin
        done <= 1'b1;
        timeout <= 1'b1;
        pass <= 1'b0;
      end
    end
  end
endmodule
